// File: rtl/fifo_pkg.sv
// Shared constants and helpers for the DRAM-backed FIFO.
package fifo_pkg;

    localparam int unsigned FIFO_DEFAULT_DEPTH = 32;
    localparam int unsigned FIFO_DEFAULT_WIDTH = 32;
    localparam int unsigned FIFO_DEFAULT_AF_TH = 28;
    localparam int unsigned FIFO_DEFAULT_AE_TH = 4;

    localparam string FIFO_MODE_FWFT = "true";
    localparam string FIFO_MODE_STD  = "false";

    // Ceiling log2; clogb2(1) = 0, clogb2(32) = 5.
    function automatic int unsigned clogb2(input int unsigned value);
        int unsigned res;
        int unsigned v;
        res = 0;
        v   = value - 1;
        while (v > 0) begin
            res = res + 1;
            v   = v >> 1;
        end
        return res;
    endfunction

endpackage

// File: rtl/fifo_dram_storage.sv
// Distributed-RAM array: synchronous write port, asynchronous read port, no output register.
module fifo_dram_storage #(
    parameter int unsigned depth = 32,
    parameter int unsigned width = 32,
    parameter int unsigned aw    = 5
) (
    input  logic             clk,
    input  logic             wen,
    input  logic [aw-1:0]    waddr,
    input  logic [width-1:0] wdata,
    input  logic [aw-1:0]    raddr,
    output logic [width-1:0] rdata
);

    logic [width-1:0] mem [depth];

    // Write port; contents are never cleared, stale words are unreachable via the pointers.
    always_ff @(posedge clk) begin
        if (wen) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/fifo_based_on_dram.sv
// Single-clock FIFO controller over a distributed-RAM store, FWFT or registered read.
// Optional macro FIFO_ALMOST_FLAGS_EN enables the registered almost-full/almost-empty flags;
// without it both flags are tied low.
module fifo_based_on_dram
    import fifo_pkg::*;
#(
    parameter int unsigned fifo_depth       = FIFO_DEFAULT_DEPTH,
    parameter int unsigned fifo_data_width  = FIFO_DEFAULT_WIDTH,
    parameter string       fwft_mode        = FIFO_MODE_FWFT,
    parameter int unsigned almost_full_th   = FIFO_DEFAULT_AF_TH,
    parameter int unsigned almost_empty_th  = FIFO_DEFAULT_AE_TH,
    parameter int unsigned simulation_delay = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       fifo_wen,
    input  logic [fifo_data_width-1:0] fifo_din,
    output logic                       fifo_full,
    output logic                       fifo_almost_full,
    input  logic                       fifo_ren,
    output logic [fifo_data_width-1:0] fifo_dout,
    output logic                       fifo_empty,
    output logic                       fifo_almost_empty,
    output logic [clogb2(fifo_depth):0] data_cnt
);

    localparam int unsigned AW = clogb2(fifo_depth);
    localparam int unsigned CW = AW + 1;

    // Parameter sanity checks at elaboration.
    if ((fifo_depth < 4) || ((fifo_depth & (fifo_depth - 1)) != 0)) begin : g_bad_depth
        $error("fifo_depth must be a power of two >= 4");
    end
    if ((almost_full_th < 1) || (almost_full_th > fifo_depth - 1) ||
        (almost_empty_th < 1) || (almost_empty_th > fifo_depth - 1)) begin : g_bad_th
        $error("almost thresholds must be in 1..fifo_depth-1");
    end
    if ((fwft_mode != FIFO_MODE_FWFT) && (fwft_mode != FIFO_MODE_STD)) begin : g_bad_mode
        $error("fwft_mode must be \"true\" or \"false\"");
    end
    if (simulation_delay > 1000) begin : g_bad_delay
        $error("simulation_delay unreasonably large");
    end

    logic [AW:0]                wptr;
    logic [AW:0]                rptr;
    logic [CW-1:0]              cnt_next_c;
    logic                       wr_acc_c;
    logic                       rd_acc_c;
    logic [fifo_data_width-1:0] ram_rdata;

    // Accept qualification and next occupancy.
    always_comb begin
        wr_acc_c   = fifo_wen & ~fifo_full;
        rd_acc_c   = fifo_ren & ~fifo_empty;
        cnt_next_c = data_cnt + CW'(wr_acc_c) - CW'(rd_acc_c);
    end

    // Pointers, count and full/empty status, all updated on the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            wptr       <= '0;
            rptr       <= '0;
            data_cnt   <= '0;
            fifo_full  <= 1'b0;
            fifo_empty <= 1'b1;
        end else begin
            if (wr_acc_c) begin
                wptr <= wptr + (AW+1)'(1);
            end
            if (rd_acc_c) begin
                rptr <= rptr + (AW+1)'(1);
            end
            data_cnt   <= cnt_next_c;
            fifo_full  <= (cnt_next_c == CW'(fifo_depth));
            fifo_empty <= (cnt_next_c == CW'(0));
        end
    end

`ifdef FIFO_ALMOST_FLAGS_EN
    // Registered threshold compares on the next occupancy.
    always_ff @(posedge clk) begin
        if (rst) begin
            fifo_almost_full  <= 1'b0;
            fifo_almost_empty <= 1'b1;
        end else begin
            fifo_almost_full  <= (cnt_next_c >= CW'(almost_full_th));
            fifo_almost_empty <= (cnt_next_c <= CW'(almost_empty_th));
        end
    end
`else
    assign fifo_almost_full  = 1'b0;
    assign fifo_almost_empty = 1'b0;
`endif

    fifo_dram_storage #(
        .depth (fifo_depth),
        .width (fifo_data_width),
        .aw    (AW)
    ) u_storage (
        .clk   (clk),
        .wen   (wr_acc_c),
        .waddr (wptr[AW-1:0]),
        .wdata (fifo_din),
        .raddr (rptr[AW-1:0]),
        .rdata (ram_rdata)
    );

    if (fwft_mode == FIFO_MODE_FWFT) begin : g_fwft
        assign fifo_dout = ram_rdata;
    end else begin : g_std
        logic [fifo_data_width-1:0] dout_q;

        // Output register captures the head word on each accepted read and holds otherwise.
        always_ff @(posedge clk) begin
            if (rst) begin
                dout_q <= '0;
            end else if (rd_acc_c) begin
                dout_q <= ram_rdata;
            end
        end

        assign fifo_dout = dout_q;
    end

endmodule
